fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RISC-V pipeline. It produces InstrD/PCD/PCPlus4D for Decode and consumes the
//  Decode redirect (PCSrcD, PCBranchD). It issues in-order requests to a latency-tolerant instruction
//  memory and buffers returned words in a DEPTH-entry prefetch FIFO. It owns the IF/ID pipeline register,
//  with stall/flush from the hazard unit.
// PARAMETERS
//  RESET_PC  32'h0000_0000  address of the first fetch after reset
//  DEPTH     4              credit limit: (in-flight requests + FIFO entries); power of 2, >=2
//  NOP       32'h0000_0013  addi x0,x0,0, loaded into InstrD on bubble/flush
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous reset, active-high
//  StallF         in   1   hazard unit: do not raise a new imem request
//  StallD         in   1   hazard unit: hold IF/ID register and FIFO head
//  FlushD         in   1   hazard unit: load bubble into IF/ID
//  PCSrcD         in   1   Decode: taken branch/jump resolved in D
//  PCBranchD      in   32  Decode: redirect target
//  imem_req_valid out  1   request valid
//  imem_req_ready in   1   memory accepts request this cycle
//  imem_req_addr  out  32  word address of request
//  imem_rsp_valid in   1   response valid; in order, >=1 cycle after accept, never back-pressured
//  imem_rsp_data  in   32  instruction word
//  InstrD         out  32  instruction in D
//  PCD            out  32  PC of InstrD
//  PCPlus4D       out  32  PCD + 4
//  ValidD         out  1   InstrD is a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async, any cycle): req PC=RESET_PC; FIFO, in-flight queue and discard state cleared;
//   imem_req_valid=0; InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0. First request may rise the cycle after rst falls.
//  redirect = PCSrcD & ~StallD. PCSrcD while StallD=1 is ignored.
//  Request: imem_req_valid rises only if ~StallF and credits available. Credits: in-flight + FIFO count
//   - (FIFO pop this cycle) < DEPTH. Once high, valid and addr are held stable until imem_req_ready,
//   regardless of StallF or redirect. On accept, next req addr = addr+4 (32-bit wrap, FFFF_FFFC -> 0).
//  Redirect: next request address = PCBranchD. If a request is pending-unaccepted, it completes with the
//   old addr; the target is issued in the following request. All requests accepted on or before the
//   redirect cycle, plus the pending one, are wrong-path. Their responses are consumed and discarded
//   (not written to FIFO, credit released). FIFO is emptied in the redirect cycle.
//   Repeated redirects before old responses return are legal; every stale response is discarded.
//  Response: a non-discarded response pushes {addr, data} into the FIFO in the cycle it arrives.
//   It is never lost: credits guarantee space. Response and redirect in the same cycle: discarded.
//  IF/ID update on each edge:
//   StallD=1: hold all D outputs and FIFO head. FlushD still wins: bubble.
//   else FlushD|redirect: InstrD=NOP, ValidD=0, PCD/PCPlus4D hold.
//   else FIFO non-empty: pop head; InstrD=data, PCD=addr, PCPlus4D=addr+4, ValidD=1.
//   else: bubble (NOP, ValidD=0).
//  Latency: no FIFO bypass. Response in cycle t -> InstrD valid from cycle t+2 with StallD=0.
//  Throughput: 1 instr/cycle with 1-cycle memory and DEPTH>=3.
//  Simultaneous push+pop keeps count; FIFO pointers wrap modulo DEPTH.
//  Assertions: FIFO never overflows. rsp_valid with zero in-flight is an error.
//   req addr[1:0]==0 always (PCBranchD[1:0]!=0 is a Decode error; bits forced 0).
// TESTING
//  1 Reset, 1-cycle mem, ready=1 -> addrs 0,4,8..; InstrD seq from reset+3 cycles; ValidD=1 every cycle.
//  2 ready=0 for 5 cycles with StallF toggling -> valid/addr held at 0x8, no duplicate, no loss.
//  3 3-cycle mem latency, 3 in flight; PCSrcD=1, PCBranchD=0x100 -> 3 stale rsps dropped;
//     next InstrD PCD=0x100; ValidD=0 in between.
//  4 StallD=1 for 4 cycles while rsps arrive -> D outputs frozen; FIFO fills to DEPTH; req_valid
//     drops; release -> in-order drain, no gaps.
//  5 PCSrcD=1 with StallD=1 -> ignored. Same cycle redirect + rsp -> rsp discarded.
//  6 rst asserted mid-stream with 2 in flight -> outputs reset immediately; after release fetch at RESET_PC.
//     Bench drops the old responses.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// It issues in-order word requests to a latency-tolerant instruction memory and
// buffers returned words in a DEPTH-entry prefetch FIFO. It also owns the IF/ID
// pipeline register, which takes stall and flush from the hazard unit.
// Ports:
//   clk, rst                        clock; asynchronous active-high reset
//   StallF, StallD, FlushD          hazard unit controls
//   PCSrcD, PCBranchD               Decode redirect and its target
//   imem_req_valid/ready/addr       request channel (valid/addr held until ready)
//   imem_rsp_valid/data             in-order response channel, never back-pressured
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register outputs
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;  // holds sums up to 2*DEPTH
  localparam logic [31:0] PC0 = RESET_PC & 32'hFFFF_FFFC;

  // address queue of accepted requests, matched to responses in order
  logic [31:0]   iq_addr [DEPTH];
  logic [AW-1:0] iq_wr, iq_rd;
  logic [CW-1:0] inflight;

  // prefetch FIFO
  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // responses still owed to wrong-path requests (always the oldest ones)
  logic [CW-1:0] discard;
  logic [31:0]   next_pc;

  logic          redirect, accept, rsp_drop, push, pop, can_issue;
  logic [CW-1:0] inflight_next, credit_used;
  logic [31:0]   target;

  always_comb begin
    redirect      = PCSrcD & ~StallD;
    accept        = imem_req_valid & imem_req_ready;
    rsp_drop      = imem_rsp_valid & (redirect | (discard != '0));
    push          = imem_rsp_valid & ~rsp_drop;
    pop           = ~StallD & ~FlushD & ~redirect & (count != '0);
    target        = PCBranchD & 32'hFFFF_FFFC;
    inflight_next = inflight + CW'(accept) - CW'(imem_rsp_valid);
    // a request accepted now stays in flight; a response only moves a credit
    // from in-flight to the FIFO, so it is not subtracted here
    credit_used   = inflight + CW'(accept) + (redirect ? '0 : (count - CW'(pop)));
    can_issue     = ~StallF & (credit_used < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (accept) iq_addr[iq_wr] <= imem_req_addr;
    if (push) begin
      fifo_addr[wr_ptr] <= iq_addr[iq_rd];
      fifo_data[wr_ptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req_valid <= 1'b0;
      imem_req_addr  <= PC0;
      next_pc        <= PC0;
      iq_wr          <= '0;
      iq_rd          <= '0;
      inflight       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      discard        <= '0;
      InstrD         <= NOP;
      PCD            <= '0;
      PCPlus4D       <= '0;
      ValidD         <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (accept)         iq_wr <= iq_wr + AW'(1);
      if (imem_rsp_valid) iq_rd <= iq_rd + AW'(1);

      // request channel: a raised request is frozen until accepted
      if (!imem_req_valid || imem_req_ready) begin
        imem_req_valid <= can_issue;
        if (can_issue) begin
          imem_req_addr <= redirect ? target : next_pc;
          next_pc       <= (redirect ? target : next_pc) + 32'd4;
        end else if (redirect) begin
          next_pc <= target;
        end
      end else if (redirect) begin
        next_pc <= target;
      end

      // every request accepted so far plus a still-pending one is wrong-path
      if (redirect)
        discard <= inflight_next + CW'(imem_req_valid & ~imem_req_ready);
      else if (imem_rsp_valid && discard != '0)
        discard <= discard - CW'(1);

      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end

      // IF/ID register; flush wins over stall, PCs hold on bubbles
      if (FlushD || redirect) begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end else if (!StallD) begin
        if (count != '0) begin
          InstrD   <= fifo_data[rd_ptr];
          PCD      <= fifo_addr[rd_ptr];
          PCPlus4D <= fifo_addr[rd_ptr] + 32'd4;
          ValidD   <= 1'b1;
        end else begin
          InstrD <= NOP;
          ValidD <= 1'b0;
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == CW'(DEPTH)));
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && inflight == '0));
  a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
    imem_req_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage. A behavioural memory
// (queue of accepted requests with due cycles) answers requests; a queue-based
// reference computes the expected IF/ID contents and request addresses each cycle.
// Ports of the DUT are all driven/observed here; no ports on this module.
module tb_fetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcD = 1'b0;
  logic [31:0] PCBranchD = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

  req_t mq[$];   // memory: accepted, not yet answered
  ent_t fq[$];   // expected prefetch FIFO contents

  int n_chk = 0, n_bad = 0;
  int cyc = 0, last_due = 0, valid_seen = 0;
  logic [31:0] m_instr, m_pc, m_pc4, nxt, prev_addr;
  logic        m_valid, prev_valid, prev_acc, prev_stallf;
  bit          pend_stale;

  int k_lat = 1, k_ready = 100, k_stallf = 0, k_stalld = 0, k_flush = 0, k_redir = 0;
  bit          f_redir = 0, f_stalld = 0;
  logic [31:0] f_target = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0100;
      1:       return {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      2:       return 32'hFFFF_FFF8;
      default: return {24'b0, 8'($urandom_range(0, 255))};
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    fq.delete();
    m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
    nxt = RESET_PC; pend_stale = 0; last_due = 0;
    prev_valid = 1'b0; prev_acc = 1'b0; prev_addr = '0; prev_stallf = 1'b0;
  endtask

  // asynchronous reset asserted mid-cycle; outstanding responses are dropped
  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0; imem_req_ready = 0;
    imem_rsp_valid = 0;
    #1;
    check_val("rst_validd", 32'(ValidD), 32'd0);
    check_val("rst_instrd", InstrD, NOP);
    check_val("rst_pcd", PCD, 32'd0);
    check_val("rst_pcp4", PCPlus4D, 32'd0);
    check_val("rst_reqv", 32'(imem_req_valid), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // one cycle: check outputs, drive inputs, advance reference to the next edge
  task automatic step();
    req_t e;
    ent_t f;
    logic redir, acc;
    int   due;
    bit   credit_ok;
    @(negedge clk);
    check_val("validd", 32'(ValidD), 32'(m_valid));
    check_val("instrd", InstrD, m_instr);
    check_val("pcd", PCD, m_pc);
    check_val("pcp4", PCPlus4D, m_pc4);
    if (ValidD) valid_seen++;
    if (imem_req_valid && (!prev_valid || prev_acc)) begin
      check_val("req_addr", imem_req_addr, nxt);
      check_val("req_stallf", 32'(prev_stallf), 32'd0);
      nxt = nxt + 32'd4;
    end
    if (prev_valid && !prev_acc) begin
      check_val("req_hold_v", 32'(imem_req_valid), 32'd1);
      check_val("req_hold_a", imem_req_addr, prev_addr);
    end
    credit_ok = (mq.size() + fq.size() + int'(imem_req_valid)) <= DEPTH;
    check_val("credit", 32'(credit_ok), 32'd1);

    StallF         = pct(k_stallf);
    imem_req_ready = pct(k_ready);
    if (f_redir) begin
      PCSrcD = 1'b1; PCBranchD = f_target; StallD = f_stalld; FlushD = 1'b0;
      f_redir = 0;
    end else begin
      StallD = pct(k_stalld); FlushD = pct(k_flush); PCSrcD = pct(k_redir);
      PCBranchD = pick_target();
    end
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end

    redir = PCSrcD & ~StallD;
    acc   = imem_req_valid & imem_req_ready;
    if (FlushD || redir) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (!StallD) begin
      if (fq.size() > 0) begin
        f = fq.pop_front();
        m_instr = f.data; m_pc = f.addr; m_pc4 = f.addr + 32'd4; m_valid = 1'b1;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    if (redir) fq.delete();
    if (imem_rsp_valid) begin
      e = mq.pop_front();
      if (!e.stale && !redir) begin
        f.addr = e.addr; f.data = imem_rsp_data;
        fq.push_back(f);
      end
    end
    if (acc) begin
      due = cyc + k_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      e.addr = imem_req_addr; e.due = due; e.stale = pend_stale;
      mq.push_back(e);
      pend_stale = 0;
    end
    if (redir) begin
      foreach (mq[i]) mq[i].stale = 1;
      if (imem_req_valid && !imem_req_ready) pend_stale = 1;
      nxt = PCBranchD & 32'hFFFF_FFFC;
    end
    prev_valid = imem_req_valid; prev_acc = acc;
    prev_addr = imem_req_addr; prev_stallf = StallF;
    cyc++;
  endtask

  initial begin
    bit found;
    model_reset();
    do_reset();

    // steady stream, 1-cycle memory: one instruction per cycle
    repeat (6) step();
    valid_seen = 0;
    repeat (20) step();
    check_val("thruput", 32'(valid_seen), 32'd20);

    // memory not ready while StallF toggles
    k_ready = 0; k_stallf = 50;
    repeat (5) step();
    k_ready = 100; k_stallf = 0;
    repeat (10) step();

    // 3-cycle memory then redirect to 0x100
    k_lat = 3;
    repeat (8) step();
    f_redir = 1; f_target = 32'h0000_0100; f_stalld = 0;
    step();
    found = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (!found && ValidD) begin
        found = 1;
        check_val("redir_pcd", PCD, 32'h0000_0100);
      end
    end
    check_val("redir_seen", 32'(found), 32'd1);

    // Decode stalled: FIFO fills and requests stop; then in-order drain
    k_lat = 1; k_stalld = 100;
    repeat (12) step();
    @(posedge clk);
    #1 check_val("full_noreq", 32'(imem_req_valid), 32'd0);
    k_stalld = 0;
    step();
    valid_seen = 0;
    repeat (8) step();
    check_val("drain", 32'(valid_seen), 32'd8);

    // redirect under StallD is ignored; redirect together with a response
    f_redir = 1; f_target = 32'h0000_0200; f_stalld = 1;
    step();
    repeat (5) step();
    f_redir = 1; f_target = 32'hFFFF_FFF8; f_stalld = 0;
    step();
    repeat (8) step();

    // reset in the middle of traffic
    k_lat = 3;
    repeat (5) step();
    do_reset();
    repeat (12) step();

    // mixed random traffic
    for (int blk = 0; blk < 12; blk++) begin
      k_lat    = int'($urandom_range(1, 4));
      k_ready  = int'($urandom_range(30, 100));
      k_stallf = int'($urandom_range(0, 30));
      k_stalld = int'($urandom_range(0, 40));
      k_flush  = int'($urandom_range(0, 10));
      k_redir  = int'($urandom_range(0, 8));
      repeat (60) step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
